// File: rtl/sdram_dev_model.sv
// sdram_dev_model: cycle-accurate single-chip 16-bit SDR SDRAM responder.
// Decodes the command bus, tracks per-bank rows and timers, applies the
// programmed CAS latency / burst length, stores data in a backing array and
// flags protocol/timing violations with a registered pulse and sticky code.
module sdram_dev_model #(
    parameter int ROW_WIDTH = 13,
    parameter int COL_WIDTH = 9,
    parameter int MEM_AW    = 16,
    parameter int T_RCD     = 2,
    parameter int T_RP      = 2,
    parameter int T_RFC     = 7
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 dev_cke_i,
    input  logic                 dev_cs_i,
    input  logic [2:0]           dev_cmd_i,
    input  logic [1:0]           dev_dqm_i,
    input  logic [ROW_WIDTH-1:0] dev_addr_i,
    input  logic [1:0]           dev_ba_i,
    input  logic [15:0]          dev_write_data_i,
    input  logic                 dev_wr_en_i,
    output logic [15:0]          dev_read_data_o,
    output logic                 viol,
    output logic [2:0]           viol_code
);
    localparam logic [2:0] CMD_NOP = 3'b111, CMD_ACT = 3'b011, CMD_RD  = 3'b101,
                           CMD_WR  = 3'b100, CMD_PRE = 3'b010, CMD_REF = 3'b001,
                           CMD_LMR = 3'b000, CMD_BST = 3'b110;
    localparam logic [3:0] TMR_MAX = 4'hF;
    localparam logic [3:0] RCD_L   = 4'(T_RCD);
    localparam logic [3:0] RP_L    = 4'(T_RP);
    localparam logic [3:0] RFC_L   = 4'(T_RFC);

    logic [15:0]          mem_q [2**MEM_AW];
    logic [3:0]           bank_open_q;
    logic [ROW_WIDTH-1:0] bank_row_q [4];
    logic [3:0]           bank_tmr_q [4];
    logic [3:0]           rfc_q;
    logic                 mode_set_q, cl2_q;
    logic [2:0]           mask_q;
    logic                 rd_active_q, rd_ap_q, wr_active_q, wr_ap_q;
    logic [1:0]           rd_ba_q, wr_ba_q;
    logic [COL_WIDTH-1:0] rd_col_q, wr_col_q;
    logic [2:0]           rd_k_q, wr_k_q;
    logic [2:0]           pipe_vld_q;
    logic [MEM_AW-1:0]    pipe_addr_q [3];
    logic [1:0]           dqm_p1_q, dqm_p2_q;
    logic [15:0]          rd_data_q;
    logic                 viol_q;
    logic [2:0]           viol_code_q;

    logic [2:0]           cmd_d, code_d;
    logic                 sel_open, in_rfc, accept_d, rd_go_d, wr_go_d, rd_stop_d;
    logic [3:0]           sel_tmr;
    logic                 gen_vld_d, wr_beat_d, out_vld;
    logic [MEM_AW-1:0]    gen_addr_d, wr_addr_d, out_addr;
    logic [15:0]          rd_word_d;

    // Backing-array index: low MEM_AW bits of {ba, row, col}; upper bits alias.
    function automatic logic [MEM_AW-1:0] mem_idx(input logic [1:0] ba,
                                                  input logic [ROW_WIDTH-1:0] row,
                                                  input logic [COL_WIDTH-1:0] col);
        return MEM_AW'({ba, row, col});
    endfunction

    // Sequential burst column: low bits wrap within the BL-aligned block.
    function automatic logic [COL_WIDTH-1:0] beat_col(input logic [COL_WIDTH-1:0] start,
                                                      input logic [2:0] k,
                                                      input logic [2:0] mask);
        logic [COL_WIDTH-1:0] m, kk;
        m  = {{(COL_WIDTH-3){1'b0}}, mask};
        kk = {{(COL_WIDTH-3){1'b0}}, k};
        return (start & ~m) | ((start + kk) & m);
    endfunction

    // Burst-length code to column wrap mask; undefined codes behave as BL=1.
    function automatic logic [2:0] bl_mask(input logic [2:0] code);
        case (code)
            3'd1:    return 3'd1;
            3'd2:    return 3'd3;
            3'd3:    return 3'd7;
            default: return 3'd0;
        endcase
    endfunction

    // Byte lanes flagged in dqm read back as zero.
    function automatic logic [15:0] mask_word(input logic [15:0] w, input logic [1:0] dqm);
        return {dqm[1] ? 8'h00 : w[15:8], dqm[0] ? 8'h00 : w[7:0]};
    endfunction

    // Command decode, violation priority, burst address generation and read output mux.
    always_comb begin
        cmd_d    = dev_cs_i ? CMD_NOP : dev_cmd_i;
        sel_open = bank_open_q[dev_ba_i];
        sel_tmr  = bank_tmr_q[dev_ba_i];
        in_rfc   = (rfc_q < RFC_L);
        code_d   = 3'd0;
        case (cmd_d)
            CMD_ACT: begin
                if (sel_open)            code_d = 3'd1;
                else if (sel_tmr < RP_L) code_d = 3'd4;
                else if (in_rfc)         code_d = 3'd5;
            end
            CMD_RD, CMD_WR: begin
                if (!sel_open)            code_d = 3'd2;
                else if (sel_tmr < RCD_L) code_d = 3'd3;
                else if (in_rfc)          code_d = 3'd5;
                else if (!mode_set_q)     code_d = 3'd6;
            end
            CMD_REF, CMD_LMR: if ((|bank_open_q) || in_rfc) code_d = 3'd5;
            CMD_PRE, CMD_BST: if (in_rfc) code_d = 3'd5;
            default: ;
        endcase
        accept_d  = (cmd_d != CMD_NOP) && (code_d == 3'd0);
        rd_go_d   = accept_d && (cmd_d == CMD_RD);
        wr_go_d   = accept_d && (cmd_d == CMD_WR);
        rd_stop_d = accept_d && ((cmd_d == CMD_BST) ||
                    ((cmd_d == CMD_PRE) && (dev_addr_i[10] || (dev_ba_i == rd_ba_q))));
        gen_vld_d  = rd_go_d || (rd_active_q && !rd_stop_d && !wr_go_d);
        gen_addr_d = rd_go_d ? mem_idx(dev_ba_i, bank_row_q[dev_ba_i], dev_addr_i[COL_WIDTH-1:0])
                             : mem_idx(rd_ba_q, bank_row_q[rd_ba_q], beat_col(rd_col_q, rd_k_q, mask_q));
        wr_beat_d  = wr_go_d || (wr_active_q && (cmd_d == CMD_NOP));
        wr_addr_d  = wr_go_d ? mem_idx(dev_ba_i, bank_row_q[dev_ba_i], dev_addr_i[COL_WIDTH-1:0])
                             : mem_idx(wr_ba_q, bank_row_q[wr_ba_q], beat_col(wr_col_q, wr_k_q, mask_q));
        if (wr_beat_d && !dev_wr_en_i) code_d = 3'd7;
        out_vld   = cl2_q ? pipe_vld_q[1] : pipe_vld_q[2];
        out_addr  = cl2_q ? pipe_addr_q[1] : pipe_addr_q[2];
        rd_word_d = (out_vld && !wr_go_d) ? mask_word(mem_q[out_addr], dqm_p2_q) : 16'h0000;
    end

    // Control state: bank rows/timers, mode register, burst generators, read pipeline, violation flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            bank_open_q <= 4'b0000;
            for (int b = 0; b < 4; b++) bank_tmr_q[b] <= TMR_MAX;
            rfc_q       <= TMR_MAX;
            mode_set_q  <= 1'b0;
            cl2_q       <= 1'b0;
            mask_q      <= 3'd0;
            rd_active_q <= 1'b0;
            wr_active_q <= 1'b0;
            pipe_vld_q  <= 3'b000;
            dqm_p1_q    <= 2'b00;
            dqm_p2_q    <= 2'b00;
            rd_data_q   <= 16'h0000;
            viol_q      <= 1'b0;
            viol_code_q <= 3'd0;
        end else if (dev_cke_i) begin
            for (int b = 0; b < 4; b++)
                if (bank_tmr_q[b] != TMR_MAX) bank_tmr_q[b] <= bank_tmr_q[b] + 4'd1;
            if (rfc_q != TMR_MAX) rfc_q <= rfc_q + 4'd1;
            viol_q <= (code_d != 3'd0);
            if (code_d != 3'd0) viol_code_q <= code_d;
            dqm_p1_q  <= dev_dqm_i;
            dqm_p2_q  <= dqm_p1_q;
            rd_data_q <= rd_word_d;
            pipe_vld_q     <= wr_go_d ? 3'b000 : {pipe_vld_q[1:0], gen_vld_d};
            pipe_addr_q[0] <= gen_addr_d;
            pipe_addr_q[1] <= pipe_addr_q[0];
            pipe_addr_q[2] <= pipe_addr_q[1];

            if (accept_d) begin
                case (cmd_d)
                    CMD_ACT: begin
                        bank_open_q[dev_ba_i] <= 1'b1;
                        bank_row_q[dev_ba_i]  <= dev_addr_i;
                        bank_tmr_q[dev_ba_i]  <= 4'd1;
                    end
                    CMD_PRE: begin
                        for (int b = 0; b < 4; b++)
                            if ((dev_addr_i[10] || (dev_ba_i == 2'(b))) && bank_open_q[b]) begin
                                bank_open_q[b] <= 1'b0;
                                bank_tmr_q[b]  <= 4'd1;
                            end
                    end
                    CMD_REF: rfc_q <= 4'd1;
                    CMD_LMR: begin
                        mode_set_q <= 1'b1;
                        cl2_q      <= (dev_addr_i[6:4] == 3'd2);
                        mask_q     <= bl_mask(dev_addr_i[2:0]);
                    end
                    default: ;
                endcase
            end

            // Read burst generator; auto-precharge closes the bank without a tRP wait.
            if (rd_go_d) begin
                rd_ba_q     <= dev_ba_i;
                rd_col_q    <= dev_addr_i[COL_WIDTH-1:0];
                rd_ap_q     <= dev_addr_i[10];
                rd_k_q      <= 3'd1;
                rd_active_q <= (mask_q != 3'd0);
                if ((mask_q == 3'd0) && dev_addr_i[10]) begin
                    bank_open_q[dev_ba_i] <= 1'b0;
                    bank_tmr_q[dev_ba_i]  <= TMR_MAX;
                end
            end else if (!gen_vld_d) begin
                rd_active_q <= 1'b0;
            end else begin
                rd_k_q <= rd_k_q + 3'd1;
                if (rd_k_q == mask_q) begin
                    rd_active_q <= 1'b0;
                    if (rd_ap_q) begin
                        bank_open_q[rd_ba_q] <= 1'b0;
                        bank_tmr_q[rd_ba_q]  <= TMR_MAX;
                    end
                end
            end

            // Write burst sequencer; any command other than NOP ends the burst.
            if (wr_go_d) begin
                wr_ba_q     <= dev_ba_i;
                wr_col_q    <= dev_addr_i[COL_WIDTH-1:0];
                wr_ap_q     <= dev_addr_i[10];
                wr_k_q      <= 3'd1;
                wr_active_q <= (mask_q != 3'd0);
                if ((mask_q == 3'd0) && dev_addr_i[10]) begin
                    bank_open_q[dev_ba_i] <= 1'b0;
                    bank_tmr_q[dev_ba_i]  <= TMR_MAX;
                end
            end else if (wr_active_q) begin
                if (cmd_d != CMD_NOP) begin
                    wr_active_q <= 1'b0;
                end else begin
                    wr_k_q <= wr_k_q + 3'd1;
                    if (wr_k_q == mask_q) begin
                        wr_active_q <= 1'b0;
                        if (wr_ap_q) begin
                            bank_open_q[wr_ba_q] <= 1'b0;
                            bank_tmr_q[wr_ba_q]  <= TMR_MAX;
                        end
                    end
                end
            end
        end
    end

    // Backing array: byte-masked write beats, skipped while clock is disabled or wr_en is low.
    always_ff @(posedge clk) begin
        if (!rst && dev_cke_i && wr_beat_d && dev_wr_en_i) begin
            if (!dev_dqm_i[0]) mem_q[wr_addr_d][7:0]  <= dev_write_data_i[7:0];
            if (!dev_dqm_i[1]) mem_q[wr_addr_d][15:8] <= dev_write_data_i[15:8];
        end
    end

    assign dev_read_data_o = rd_data_q;
    assign viol            = viol_q;
    assign viol_code       = viol_code_q;
endmodule

// File: tb/tb_sdram_dev_model.sv
// Directed bench for sdram_dev_model: mode programming, write/read bursts,
// DQM masking, timing/protocol violations and mid-burst reset.
module tb_sdram_dev_model;
    localparam logic [2:0] NOP = 3'b111, ACT = 3'b011, RD = 3'b101, WR = 3'b100,
                           PRE = 3'b010, REF = 3'b001, LMR = 3'b000;

    logic        clk = 1'b0;
    logic        rst, cke, cs, wr_en;
    logic [2:0]  cmd;
    logic [1:0]  dqm, ba;
    logic [12:0] addr;
    logic [15:0] wdata, rdata;
    logic        viol;
    logic [2:0]  viol_code;
    int          vectors = 0;
    int          miscompares = 0;

    sdram_dev_model dut (
        .clk              (clk),
        .rst              (rst),
        .dev_cke_i        (cke),
        .dev_cs_i         (cs),
        .dev_cmd_i        (cmd),
        .dev_dqm_i        (dqm),
        .dev_addr_i       (addr),
        .dev_ba_i         (ba),
        .dev_write_data_i (wdata),
        .dev_wr_en_i      (wr_en),
        .dev_read_data_o  (rdata),
        .viol             (viol),
        .viol_code        (viol_code)
    );

    always #5 clk = ~clk;

    task automatic step(input logic [2:0] c, input logic [1:0] b, input logic [12:0] a,
                        input logic [15:0] wd, input logic [1:0] dq);
        cmd = c; ba = b; addr = a; wdata = wd; dqm = dq;
        @(posedge clk);
        #1;
    endtask

    task automatic nop();
        step(NOP, 2'd0, 13'h0, 16'h0, 2'b00);
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; cke = 1'b1; cs = 1'b0; wr_en = 1'b1;
        nop(); nop();
        check("reset_rdata", rdata, 16'h0000);
        check("reset_viol", 16'(viol), 16'h0000);
        check("reset_code", 16'(viol_code), 16'h0000);
        rst = 1'b0;

        // Protocol violations before mode programming
        step(ACT, 2'd0, 13'h000, 16'h0, 2'b00);
        check("act_ok", 16'(viol), 16'h0000);
        nop(); nop();
        step(RD, 2'd0, 13'h000, 16'h0, 2'b00);
        check("rd_nomode_viol", 16'(viol), 16'h0001);
        check("rd_nomode_code", 16'(viol_code), 16'h0006);
        nop();
        check("viol_pulse_end", 16'(viol), 16'h0000);
        check("code_hold", 16'(viol_code), 16'h0006);
        step(ACT, 2'd0, 13'h010, 16'h0, 2'b00);
        check("act_open_code", 16'(viol_code), 16'h0001);
        step(REF, 2'd0, 13'h000, 16'h0, 2'b00);
        check("ref_open_code", 16'(viol_code), 16'h0005);

        // CL=2 BL=4 write burst then wrapped read burst
        step(PRE, 2'd0, 13'h400, 16'h0, 2'b00);
        nop();
        step(LMR, 2'd0, 13'h022, 16'h0, 2'b00);
        nop();
        step(ACT, 2'd1, 13'h0AB, 16'h0, 2'b00);
        nop();
        step(WR,  2'd1, 13'h004, 16'h1111, 2'b00);
        step(NOP, 2'd0, 13'h000, 16'h2222, 2'b00);
        step(NOP, 2'd0, 13'h000, 16'h3333, 2'b00);
        step(NOP, 2'd0, 13'h000, 16'h4444, 2'b00);
        check("wr_burst_noviol", 16'(viol), 16'h0000);
        step(RD, 2'd1, 13'h006, 16'h0, 2'b00);
        check("rd_t0", rdata, 16'h0000);
        nop(); check("rd_t1", rdata, 16'h0000);
        nop(); check("rd_beat0", rdata, 16'h3333);
        nop(); check("rd_beat1", rdata, 16'h4444);
        nop(); check("rd_beat2", rdata, 16'h1111);
        nop(); check("rd_beat3", rdata, 16'h2222);
        nop(); check("rd_after", rdata, 16'h0000);
        check("rd_burst_noviol", 16'(viol), 16'h0000);

        // tRCD violation leaves the array untouched
        step(PRE, 2'd1, 13'h000, 16'h0, 2'b00);
        nop();
        step(ACT, 2'd1, 13'h0AB, 16'h0, 2'b00);
        step(WR,  2'd1, 13'h004, 16'hDEAD, 2'b00);
        check("trcd_viol", 16'(viol), 16'h0001);
        check("trcd_code", 16'(viol_code), 16'h0003);
        nop();
        step(RD, 2'd1, 13'h004, 16'h0, 2'b00);
        nop();
        nop(); check("trcd_unchanged0", rdata, 16'h1111);
        nop(); check("trcd_unchanged1", rdata, 16'h2222);
        nop(); nop(); nop();

        // CL=3 BL=1 latency and read DQM
        step(PRE, 2'd0, 13'h400, 16'h0, 2'b00);
        nop();
        step(LMR, 2'd0, 13'h030, 16'h0, 2'b00);
        nop();
        step(ACT, 2'd1, 13'h0AB, 16'h0, 2'b00);
        nop();
        step(RD, 2'd1, 13'h006, 16'h0, 2'b00);
        nop();
        nop(); check("cl3_t2", rdata, 16'h0000);
        nop(); check("cl3_t3", rdata, 16'h3333);
        step(RD,  2'd1, 13'h005, 16'h0, 2'b00);
        step(NOP, 2'd0, 13'h000, 16'h0, 2'b10);
        nop();
        nop(); check("dqm_hi_masked", rdata, 16'h0022);
        nop(); check("bl1_done", rdata, 16'h0000);

        // Refresh window
        step(PRE, 2'd0, 13'h400, 16'h0, 2'b00);
        step(REF, 2'd0, 13'h000, 16'h0, 2'b00);
        check("ref_ok", 16'(viol), 16'h0000);
        nop(); nop();
        step(ACT, 2'd0, 13'h000, 16'h0, 2'b00);
        check("rfc_act3_viol", 16'(viol), 16'h0001);
        check("rfc_act3_code", 16'(viol_code), 16'h0005);
        nop(); nop();
        step(ACT, 2'd0, 13'h000, 16'h0, 2'b00);
        check("rfc_act6_viol", 16'(viol), 16'h0001);
        step(ACT, 2'd0, 13'h000, 16'h0, 2'b00);
        check("rfc_act7_ok", 16'(viol), 16'h0000);
        check("rfc_code_hold", 16'(viol_code), 16'h0005);

        // BL=8 read interrupted by reset
        step(PRE, 2'd0, 13'h400, 16'h0, 2'b00);
        nop();
        step(LMR, 2'd0, 13'h033, 16'h0, 2'b00);
        nop();
        step(ACT, 2'd1, 13'h0AB, 16'h0, 2'b00);
        nop();
        step(RD, 2'd1, 13'h004, 16'h0, 2'b00);
        nop(); nop();
        nop(); check("bl8_beat0", rdata, 16'h1111);
        nop(); check("bl8_beat1", rdata, 16'h2222);
        nop(); check("bl8_beat2", rdata, 16'h3333);
        rst = 1'b1;
        nop(); check("rst_midburst", rdata, 16'h0000);
        check("rst_code", 16'(viol_code), 16'h0000);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            nop();
            check("rst_no_beats", rdata, 16'h0000);
        end
        check("rst_noviol", 16'(viol), 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/sdram_dev_model.md
# sdram_dev_model

Cycle-accurate single-chip SDR SDRAM responder sitting on the subordinate end of `sdram_dev_if`. It stands in for the external 16-bit SDRAM in controller benches and in loopback builds. It decodes the command bus, tracks per-bank row state, applies the programmed CAS latency and burst length, and stores data in a parameterised backing array. It also flags protocol and timing violations so controller regressions can self-check.

## Interface
- `ROW_WIDTH`, 13: row address bits; also the width of `dev.addr`.
- `COL_WIDTH`, 9: column address bits, taken from `addr[COL_WIDTH-1:0]`.
- `MEM_AW`, 16: backing array index width. Index = low `MEM_AW` bits of {ba, row, col}; higher bits alias.
- `T_RCD`, 2: minimum cycles from ACTIVE to READ/WRITE on the same bank.
- `T_RP`, 2: minimum cycles from PRECHARGE to ACTIVE on the same bank.
- `T_RFC`, 7: cycles after AUTO REFRESH during which any non-NOP command is a violation.
- `clk`  in  1  sole clock.
- `rst`  in  1  synchronous, active-high reset.
- `dev`  sdram_dev_if.sub  —  inputs `cke`, `cs`, `cmd`, `dqm`, `addr`, `ba`, `write_data`, `wr_en`; output `read_data[15:0]`.
- `viol`  out  1  one-cycle pulse when a violation is detected.
- `viol_code`  out  3  code of the last violation; holds until the next violation.

## Operation
- Commands are sampled on the rising edge of `clk` when `cke`=1 and `cs`=0.
  - With `cs`=1, the command is treated as NOP.
  - With `cke`=0, the command is ignored and all counters, burst generators and pipelines freeze. `read_data` holds its value.
- `cmd` = {ras_n, cas_n, we_n}:
  - 111 NOP.
  - 011 ACTIVE: opens row `addr` in bank `ba`.
  - 101 READ.
  - 100 WRITE.
  - 010 PRECHARGE: `addr[10]`=1 closes all banks, otherwise closes bank `ba`.
  - 001 AUTO REFRESH.
  - 000 LOAD MODE: `addr[2:0]` = burst length code (0→1, 1→2, 2→4, 3→8; others are treated as 1). `addr[6:4]` = CAS latency (2 or 3; others are treated as 3).
  - 110 BURST TERMINATE.
- Per-bank state: IDLE or ACTIVE(row), plus a timer since the last ACTIVE or PRECHARGE.
- READ/WRITE use `addr[COL_WIDTH-1:0]` as the start column. `addr[10]`=1 requests auto-precharge: the bank returns to IDLE after the last burst beat, with no tRP check afterwards.
- Burst addressing is sequential and wraps within a BL-aligned block. Col low log2(BL) bits increment mod BL; upper col bits are fixed.
- Read path:
  - A burst generator emits one word address per cycle into a delay pipeline of length CL.
  - At the pipeline output, `read_data` is loaded with the array word. If that word is masked by `dqm` (see Timing), or no word is due, `read_data` is loaded with 0.
  - A new READ restarts the generator. Words already in the pipeline still emerge.
  - WRITE stops the generator and flushes the pipeline.
  - PRECHARGE to the bursting bank and BURST TERMINATE stop the generator only.
- Write path:
  - The beat at the WRITE command cycle and the next BL-1 cycles each capture `write_data`.
  - `dqm[0]`=1 masks the low byte and `dqm[1]`=1 masks the high byte, in the same cycle.
  - Any new command ends the write burst.
- Violations: the command is ignored, `viol` pulses, and `viol_code` is set. If several apply, the lowest code wins.
  - 1: ACTIVE to a bank already ACTIVE.
  - 2: READ/WRITE to an IDLE bank.
  - 3: READ/WRITE before T_RCD has elapsed.
  - 4: ACTIVE before T_RP has elapsed.
  - 5: AUTO REFRESH or LOAD MODE with any bank ACTIVE, or any non-NOP inside the T_RFC window.
  - 6: READ/WRITE before the first LOAD MODE.
  - 7: write beat with `wr_en`=0. That beat is not written; the burst continues.

## Timing
- Reset values:
  - `read_data`=0, `viol`=0, `viol_code`=0.
  - All banks IDLE with timers saturated (no tRP pending).
  - Mode unprogrammed; defaults CL=3, BL=1.
  - Pipelines and burst generators empty.
- Reset applies on any edge with `rst`=1, including mid-burst. Outstanding read words are discarded.
- READ sampled at edge t: beat k appears on `read_data` after edge t+CL+k, for k=0..BL-1. Data reflects all writes captured at or before edge t+CL+k-1.
- Read DQM latency is 2: `dqm`≠0 sampled at edge e zeroes the word output at edge e+2. The high and low bytes are masked independently.
- Write latency is 0: write data is captured at the same edge as the WRITE command.
- Timer rules: the same-bank command at edge t+T_RCD after ACTIVE at edge t is legal; at edge t+T_RCD-1 it is code 3. The same rule applies to T_RP with code 4.
- T_RFC window: after AUTO REFRESH at edge t, edges t+1..t+T_RFC-1 accept only NOP.
- `viol` is registered and asserts the cycle after the offending edge.
- Different banks may hold open rows at the same time; banks are interleaved freely.

## Test plan
- Reset, then LOAD MODE with CL=2, BL=4. Then ACTIVE bank 1 row 0x0AB, wait 2 cycles, WRITE col 0x004 with data 0x1111, 0x2222, 0x3333, 0x4444. Then READ col 0x006 → `read_data` shows 0x3333, 0x4444, 0x1111, 0x2222 starting at edge t+2; `viol` never asserts.
- CL=3, BL=1: READ with `dqm`=2'b10 at edge t+1 → the word at edge t+3 has its high byte zero.
- WRITE issued one cycle after ACTIVE (T_RCD=2) → `viol` pulses with `viol_code`=3, and the array is unchanged.
- READ issued before any LOAD MODE → `viol_code`=6. ACTIVE on an already-open bank → `viol_code`=1.
- AUTO REFRESH with bank 0 open → code 5. PRECHARGE with `addr[10]`=1, then AUTO REFRESH, then ACTIVE at +3 cycles (T_RFC=7) → code 5.
- BL=8 read burst with `rst` asserted at beat 3 → `read_data`=0 from the next edge, and no further beats appear.
